// File: rtl/spi_frame_tx_if.sv
// SPI pins, link-alive qualifier and frame status exchanged between a SPI master and spi_frame_tx.
interface spi_frame_tx_if;
    logic       sclk;
    logic       cs_n;
    logic       detect;
    logic       miso;
    logic       busy;
    logic       frame_done;
    logic [7:0] frame_cnt;

    modport slave (
        input  sclk, cs_n, detect,
        output miso, busy, frame_done, frame_cnt
    );

    modport master (
        output sclk, cs_n, detect,
        input  miso, busy, frame_done, frame_cnt
    );
endinterface

// File: rtl/spi_frame_tx.sv
// Dummy camera SPI slave: streams a (x + y + frame count) test pattern on MISO, MSB first, SPI mode 0.
// Defining SPI_FRAME_TX_HEADER_EN prefixes every frame with the words 0xA5 and the frame count.
module spi_frame_tx #(
    parameter int WIDTH    = 64,
    parameter int HEIGHT   = 64,
    parameter int PIX_BITS = 8
) (
    input  logic          CLK,
    input  logic          RST,
    spi_frame_tx_if.slave bus
);
    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BW = (PIX_BITS > 1) ? $clog2(PIX_BITS) : 1;
    localparam logic [BW-1:0] BIT_TOP = BW'(PIX_BITS - 1);
    localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    logic [1:0]          state;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic [BW-1:0]       bit_idx;
    logic [PIX_BITS-2:0] shreg;
    logic                shift_out;
    logic                done_pulse;
    logic [7:0]          frame_count;

    logic [2:0] sclk_sync;
    logic [2:0] cs_sync;
    logic       sclk_fall;
    logic       cs_high;

    logic                end_of_line;
    logic                end_of_frame;
    logic [XW-1:0]       adv_x;
    logic [YW-1:0]       adv_y;
    logic [7:0]          adv_cnt;
    logic [XW-1:0]       next_x;
    logic [YW-1:0]       next_y;
    logic [7:0]          next_cnt;
    logic                next_done;
    logic [PIX_BITS-1:0] start_word;
    logic [PIX_BITS-1:0] next_word;

`ifdef SPI_FRAME_TX_HEADER_EN
    localparam logic [PIX_BITS-1:0] HDR_SYNC = PIX_BITS'(8'hA5);
    // 0: sync word, 1: frame-count word, 2: pixel stream
    logic [1:0] hdr_idx;
    logic [1:0] next_hdr;
`endif

    function automatic logic [PIX_BITS-1:0] pix_of(input logic [XW-1:0] px,
                                                   input logic [YW-1:0] py,
                                                   input logic [7:0]    pc);
        return PIX_BITS'(px) + PIX_BITS'(py) + PIX_BITS'(pc);
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            sclk_sync <= 3'b000;
            cs_sync   <= 3'b111;
        end else begin
            sclk_sync <= {sclk_sync[1:0], bus.sclk};
            cs_sync   <= {cs_sync[1:0], bus.cs_n};
        end
    end

    assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];
    assign cs_high   = cs_sync[2];

    // start_word opens a transaction; next_* describe the stream once the current word completes.
    always_comb begin
        end_of_line  = (x == X_LAST);
        end_of_frame = end_of_line && (y == Y_LAST);
        adv_x        = end_of_line ? '0 : x + 1'b1;
        adv_y        = end_of_frame ? '0 : (end_of_line ? y + 1'b1 : y);
        adv_cnt      = end_of_frame ? frame_count + 8'd1 : frame_count;
        next_x       = adv_x;
        next_y       = adv_y;
        next_cnt     = adv_cnt;
        next_done    = end_of_frame;
        next_word    = pix_of(adv_x, adv_y, adv_cnt);
        start_word   = pix_of(x, y, frame_count);
`ifdef SPI_FRAME_TX_HEADER_EN
        next_hdr = hdr_idx;
        if (hdr_idx == 2'd0) begin
            start_word = HDR_SYNC;
            next_hdr   = 2'd1;
            next_x     = x;
            next_y     = y;
            next_cnt   = frame_count;
            next_done  = 1'b0;
            next_word  = PIX_BITS'(frame_count);
        end else if (hdr_idx == 2'd1) begin
            start_word = PIX_BITS'(frame_count);
            next_hdr   = 2'd2;
            next_x     = x;
            next_y     = y;
            next_cnt   = frame_count;
            next_done  = 1'b0;
            next_word  = pix_of(x, y, frame_count);
        end else if (end_of_frame) begin
            next_hdr  = 2'd0;
            next_word = HDR_SYNC;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            x           <= '0;
            y           <= '0;
            bit_idx     <= BIT_TOP;
            shreg       <= '0;
            shift_out   <= 1'b0;
            done_pulse  <= 1'b0;
            frame_count <= '0;
`ifdef SPI_FRAME_TX_HEADER_EN
            hdr_idx     <= 2'd0;
`endif
        end else begin
            done_pulse <= 1'b0;
            if (state != S_IDLE && !bus.detect) begin
                // Link lost: the frame restarts from its origin but the frame count survives.
                state     <= S_IDLE;
                x         <= '0;
                y         <= '0;
                bit_idx   <= BIT_TOP;
                shift_out <= 1'b0;
`ifdef SPI_FRAME_TX_HEADER_EN
                hdr_idx   <= 2'd0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        shift_out <= 1'b0;
                        if (bus.detect) begin
                            state <= S_ARM;
                        end
                    end
                    S_ARM: begin
                        if (cs_high) begin
                            shift_out <= 1'b0;
                        end else begin
                            state     <= S_SHIFT;
                            shreg     <= start_word[PIX_BITS-2:0];
                            shift_out <= start_word[PIX_BITS-1];
                            bit_idx   <= BIT_TOP;
                        end
                    end
                    S_SHIFT: begin
                        if (cs_high) begin
                            // Partial word is dropped; x/y hold so the word is resent whole.
                            state     <= S_ARM;
                            shift_out <= 1'b0;
                            bit_idx   <= BIT_TOP;
`ifdef SPI_FRAME_TX_HEADER_EN
                            if (hdr_idx != 2'd2) begin
                                hdr_idx <= 2'd0;
                            end
`endif
                        end else if (sclk_fall) begin
                            if (bit_idx != '0) begin
                                shift_out <= shreg[PIX_BITS-2];
                                shreg     <= shreg << 1;
                                bit_idx   <= bit_idx - 1'b1;
                            end else begin
                                x           <= next_x;
                                y           <= next_y;
                                frame_count <= next_cnt;
                                done_pulse  <= next_done;
                                shreg       <= next_word[PIX_BITS-2:0];
                                shift_out   <= next_word[PIX_BITS-1];
                                bit_idx     <= BIT_TOP;
`ifdef SPI_FRAME_TX_HEADER_EN
                                hdr_idx     <= next_hdr;
`endif
                            end
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        shift_out <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.miso       = shift_out;
    assign bus.busy       = (state == S_SHIFT);
    assign bus.frame_done = done_pulse;
    assign bus.frame_cnt  = frame_count;
endmodule
